// File: rtl/mux2_stream_arb.sv
// Two-channel round-robin packet arbiter driving the select of a mux2 bit-slice bank.
// The grant is locked for a whole packet, and the muxed beat is registered onto a ready/valid output stream.
module mux2_stream_arb #(
    parameter int WIDTH    = 8,
    parameter int HOLD_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0,
    input  logic             v0,
    input  logic             l0,
    output logic             r0,
    input  logic [WIDTH-1:0] in1,
    input  logic             v1,
    input  logic             l1,
    output logic             r1,
    output logic             s,
    output logic [WIDTH-1:0] q,
    output logic             qv,
    output logic             ql,
    input  logic             qr,
    output logic             err
);

    localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [CW-1:0] HOLD_SAT  = CW'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             s_reg;
    logic [WIDTH-1:0] q_reg;
    logic             qv_reg;
    logic             ql_reg;
    logic             err_reg;
    logic             last_served_reg;
    logic [CW-1:0]    hold_cnt_reg;

    logic [WIDTH-1:0] mux_out;
    logic [1:0]       v_vec;
    logic [1:0]       l_vec;
    logic             granted;
    logic             gnt_ch;
    logic             ch_v;
    logic             ch_l;
    logic             out_free;
    logic             accept;
    logic             pkt_end;
    logic             timeout;

    // The mux2 bank: one slice per data bit, all steered by the registered select.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign mux_out[gi] = s_reg ? in1[gi] : in0[gi];
        end
    endgenerate

    assign v_vec    = {v1, v0};
    assign l_vec    = {l1, l0};
    assign granted  = (state_reg != IDLE);
    assign gnt_ch   = (state_reg == GNT1);
    assign ch_v     = v_vec[gnt_ch];
    assign ch_l     = l_vec[gnt_ch];
    assign out_free = ~qv_reg | qr;
    assign accept   = granted & ch_v & out_free;
    assign pkt_end  = accept & ch_l;

    // A timeout requires the granted valid to be low, so it can never coincide with a last-beat accept.
    generate
        if (HOLD_MAX > 0) begin : g_hold
            assign timeout = granted & ~ch_v & (hold_cnt_reg == HOLD_LAST);
        end else begin : g_nohold
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (v0 && v1) begin
                    state_next = last_served_reg ? GNT0 : GNT1;
                end else if (v0) begin
                    state_next = GNT0;
                end else if (v1) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (pkt_end || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r0 = 1'b0;
        r1 = 1'b0;
        if (state_reg == GNT0) begin
            r0 = out_free;
        end
        if (state_reg == GNT1) begin
            r1 = out_free;
        end
    end

    // Select moves only when a grant is taken; in IDLE it keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg <= 1'b0;
        end else if (state_reg == IDLE && state_next == GNT0) begin
            s_reg <= 1'b0;
        end else if (state_reg == IDLE && state_next == GNT1) begin
            s_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg  <= '0;
            qv_reg <= 1'b0;
            ql_reg <= 1'b0;
        end else if (accept) begin
            q_reg  <= mux_out;
            qv_reg <= 1'b1;
            ql_reg <= ch_l;
        end else if (qv_reg && qr) begin
            qv_reg <= 1'b0;
            ql_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served_reg <= 1'b1;
            err_reg         <= 1'b0;
        end else begin
            err_reg <= timeout;
            if (pkt_end || timeout) begin
                last_served_reg <= gnt_ch;
            end
        end
    end

    // Counts only starved cycles; a stalled-but-valid channel is not considered idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
        end else if (!granted || accept || state_next == IDLE) begin
            hold_cnt_reg <= '0;
        end else if (!ch_v && hold_cnt_reg != HOLD_SAT) begin
            hold_cnt_reg <= hold_cnt_reg + CW'(1);
        end
    end

    assign s   = s_reg;
    assign q   = q_reg;
    assign qv  = qv_reg;
    assign ql  = ql_reg;
    assign err = err_reg;

endmodule

// File: tb/tb_mux2_stream_arb.sv
// Directed bench for mux2_stream_arb: a per-cycle vector table plus hand-written
// sequences for hold timeout and reset in the middle of a packet.
module tb_mux2_stream_arb;

    logic       clk;
    logic       rst;
    logic [7:0] in0, in1;
    logic       v0, l0, v1, l1, qr;
    logic       r0, r1, s, qv, ql, err;
    logic [7:0] q;

    int passed = 0;
    int total  = 0;

    mux2_stream_arb #(.WIDTH(8), .HOLD_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .in0(in0), .v0(v0), .l0(l0), .r0(r0),
        .in1(in1), .v1(v1), .l1(l1), .r1(r1),
        .s(s), .q(q), .qv(qv), .ql(ql), .qr(qr), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       v0;
        logic       l0;
        logic [7:0] in0;
        logic       v1;
        logic       l1;
        logic [7:0] in1;
        logic       qr;
        logic       s;
        logic [7:0] q;
        logic       qv;
        logic       ql;
        logic       r0;
        logic       r1;
        logic       err;
    } vec_t;

    function automatic vec_t mk(input logic a_rst, a_v0, a_l0, input logic [7:0] a_in0,
                                input logic a_v1, a_l1, input logic [7:0] a_in1, input logic a_qr,
                                input logic e_s, input logic [7:0] e_q,
                                input logic e_qv, e_ql, e_r0, e_r1, e_err);
        vec_t v;
        v.rst = a_rst; v.v0 = a_v0; v.l0 = a_l0; v.in0 = a_in0;
        v.v1 = a_v1; v.l1 = a_l1; v.in1 = a_in1; v.qr = a_qr;
        v.s = e_s; v.q = e_q; v.qv = e_qv; v.ql = e_ql;
        v.r0 = e_r0; v.r1 = e_r1; v.err = e_err;
        return v;
    endfunction

    // Drive one cycle's inputs and move to the sampling point (falling edge).
    task automatic cyc(input logic a_rst, a_v0, a_l0, input logic [7:0] a_in0,
                       input logic a_v1, a_l1, input logic [7:0] a_in1, input logic a_qr);
        rst = a_rst; v0 = a_v0; l0 = a_l0; in0 = a_in0;
        v1 = a_v1; l1 = a_l1; in1 = a_in1; qr = a_qr;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // QL is only meaningful alongside QV, so it is compared masked by QV.
    task automatic chk(input string name, input logic e_s, input logic [7:0] e_q,
                       input logic e_qv, e_ql, e_r0, e_r1, e_err);
        logic [14:0] got, want;
        got  = {s, q, qv, ql & qv, r0, r1, err};
        want = {e_s, e_q, e_qv, e_ql & e_qv, e_r0, e_r1, e_err};
        total++;
        if (got !== want) begin
            $display("FAIL %s: got s=%b q=%h qv=%b ql=%b r0=%b r1=%b err=%b, want s=%b q=%h qv=%b ql=%b r0=%b r1=%b err=%b",
                     name, s, q, qv, ql, r0, r1, err, e_s, e_q, e_qv, e_ql, e_r0, e_r1, e_err);
        end else begin
            passed++;
        end
    endtask

    vec_t tbl[29];

    initial begin
        // Reset, single 3-beat packet on channel 0 (A,B,C)
        tbl[0]  = mk(1, 0,0,8'h00, 0,0,8'h00, 1,  0,8'h00, 0,0, 0,0, 0);
        tbl[1]  = mk(1, 0,0,8'h00, 0,0,8'h00, 1,  0,8'h00, 0,0, 0,0, 0);
        tbl[2]  = mk(0, 1,0,8'hA1, 0,0,8'h00, 1,  0,8'h00, 0,0, 0,0, 0);
        tbl[3]  = mk(0, 1,0,8'hA1, 0,0,8'h00, 1,  0,8'h00, 0,0, 1,0, 0);
        tbl[4]  = mk(0, 1,0,8'hB2, 0,0,8'h00, 1,  0,8'hA1, 1,0, 1,0, 0);
        tbl[5]  = mk(0, 1,1,8'hC3, 0,0,8'h00, 1,  0,8'hB2, 1,0, 1,0, 0);
        tbl[6]  = mk(0, 0,0,8'h00, 0,0,8'h00, 1,  0,8'hC3, 1,1, 0,0, 0);
        tbl[7]  = mk(0, 0,0,8'h00, 0,0,8'h00, 1,  0,8'hC3, 0,0, 0,0, 0);
        // Contention from reset, 1-beat packets: grants 0,1,0,1
        tbl[8]  = mk(1, 0,0,8'h00, 0,0,8'h00, 1,  0,8'hC3, 0,0, 0,0, 0);
        tbl[9]  = mk(0, 1,1,8'h10, 1,1,8'h20, 1,  0,8'h00, 0,0, 0,0, 0);
        tbl[10] = mk(0, 1,1,8'h11, 1,1,8'h21, 1,  0,8'h00, 0,0, 1,0, 0);
        tbl[11] = mk(0, 1,1,8'h12, 1,1,8'h22, 1,  0,8'h11, 1,1, 0,0, 0);
        tbl[12] = mk(0, 1,1,8'h13, 1,1,8'h23, 1,  1,8'h11, 0,0, 0,1, 0);
        tbl[13] = mk(0, 1,1,8'h14, 1,1,8'h24, 1,  1,8'h23, 1,1, 0,0, 0);
        tbl[14] = mk(0, 1,1,8'h15, 1,1,8'h25, 1,  0,8'h23, 0,0, 1,0, 0);
        tbl[15] = mk(0, 1,1,8'h16, 1,1,8'h26, 1,  0,8'h15, 1,1, 0,0, 0);
        tbl[16] = mk(0, 1,1,8'h17, 1,1,8'h27, 1,  1,8'h15, 0,0, 0,1, 0);
        tbl[17] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,  1,8'h27, 1,1, 0,0, 0);
        // Backpressure: 3-beat packet on channel 0 with QR toggling
        tbl[18] = mk(0, 1,0,8'h31, 0,0,8'h00, 0,  1,8'h27, 0,0, 0,0, 0);
        tbl[19] = mk(0, 1,0,8'h31, 0,0,8'h00, 0,  0,8'h27, 0,0, 1,0, 0);
        tbl[20] = mk(0, 1,0,8'h32, 0,0,8'h00, 0,  0,8'h31, 1,0, 0,0, 0);
        tbl[21] = mk(0, 1,0,8'h32, 0,0,8'h00, 0,  0,8'h31, 1,0, 0,0, 0);
        tbl[22] = mk(0, 1,0,8'h32, 0,0,8'h00, 1,  0,8'h31, 1,0, 1,0, 0);
        tbl[23] = mk(0, 1,1,8'h33, 0,0,8'h00, 0,  0,8'h32, 1,0, 0,0, 0);
        tbl[24] = mk(0, 1,1,8'h33, 0,0,8'h00, 1,  0,8'h32, 1,0, 1,0, 0);
        tbl[25] = mk(0, 0,0,8'h00, 0,0,8'h00, 0,  0,8'h33, 1,1, 0,0, 0);
        tbl[26] = mk(0, 0,0,8'h00, 0,0,8'h00, 0,  0,8'h33, 1,1, 0,0, 0);
        tbl[27] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,  0,8'h33, 1,1, 0,0, 0);
        tbl[28] = mk(0, 0,0,8'h00, 0,0,8'h00, 1,  0,8'h33, 0,0, 0,0, 0);

        rst = 1'b1; v0 = 1'b0; l0 = 1'b0; in0 = 8'h00;
        v1 = 1'b0; l1 = 1'b0; in1 = 8'h00; qr = 1'b1;
        adv();

        for (int i = 0; i < 29; i++) begin
            cyc(tbl[i].rst, tbl[i].v0, tbl[i].l0, tbl[i].in0,
                tbl[i].v1, tbl[i].l1, tbl[i].in1, tbl[i].qr);
            chk($sformatf("vec%0d", i), tbl[i].s, tbl[i].q, tbl[i].qv, tbl[i].ql,
                tbl[i].r0, tbl[i].r1, tbl[i].err);
            adv();
        end

        // Timeout: channel 1 sends one beat then starves for 15 cycles; channel 0 waits.
        cyc(0, 0,0,8'h00, 1,0,8'h41, 1);
        adv();
        cyc(0, 0,0,8'h00, 1,0,8'h41, 1);
        chk("to_beat", 1, 8'h33, 0, 0, 0, 1, 0);
        adv();
        for (int k = 1; k <= 15; k++) begin
            cyc(0, 1,1,8'h50, 0,0,8'h00, 1);
            chk($sformatf("to_idle%0d", k), 1, 8'h41, (k == 1), 0, 0, 1, 0);
            adv();
        end
        cyc(0, 1,1,8'h50, 0,0,8'h00, 1);
        chk("to_err", 1, 8'h41, 0, 0, 0, 0, 1);
        adv();
        cyc(0, 1,1,8'h50, 0,0,8'h00, 1);
        chk("to_next_gnt", 0, 8'h41, 0, 0, 1, 0, 0);
        adv();
        cyc(0, 0,0,8'h00, 0,0,8'h00, 1);
        chk("to_next_q", 0, 8'h50, 1, 1, 0, 0, 0);
        adv();

        // Reset during beat 2 of a 4-beat channel-1 packet; channel 0 must win afterwards.
        cyc(0, 0,0,8'h00, 1,0,8'h61, 1);
        adv();
        cyc(0, 0,0,8'h00, 1,0,8'h61, 1);
        chk("rm_beat1", 1, 8'h50, 0, 0, 0, 1, 0);
        adv();
        cyc(1, 0,0,8'h00, 1,0,8'h62, 1);
        chk("rm_beat2", 1, 8'h61, 1, 0, 0, 1, 0);
        adv();
        cyc(0, 1,1,8'h70, 1,0,8'h63, 1);
        chk("rm_after_rst", 0, 8'h00, 0, 0, 0, 0, 0);
        adv();
        cyc(0, 1,1,8'h70, 1,0,8'h63, 1);
        chk("rm_gnt0", 0, 8'h00, 0, 0, 1, 0, 0);
        adv();
        cyc(0, 0,0,8'h00, 0,0,8'h00, 1);
        chk("rm_q", 0, 8'h70, 1, 1, 0, 0, 0);
        adv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
